// File: rtl/mux4x1_rr_merge_if.sv
// Handshake bundle between four upstream lanes, the merge block and one downstream consumer.
// Latency: none (signal bundle only).
// Backpressure: in_ready carries per-lane acceptance; out_ready carries downstream acceptance.
// Ports (signals):
//   in0..in3  lane payloads           in_valid/in_ready  per-lane handshake (bit k = lane k)
//   out_data  merged payload          out_sel            source lane of out_data
//   out_valid/out_ready               downstream handshake
// Modports: master = traffic source/sink side (bench or neighbours), slave = merge block.
interface mux4x1_rr_merge_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] in0;
  logic [DATA_W-1:0] in1;
  logic [DATA_W-1:0] in2;
  logic [DATA_W-1:0] in3;
  logic [3:0]        in_valid;
  logic [3:0]        in_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_sel;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in0, in1, in2, in3, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  in0, in1, in2, in3, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/mux4x1_rr_merge.sv
// Merges four valid/ready lanes onto one registered stream using a round-robin arbiter.
// Latency: 1 cycle from lane transfer to out_valid; 1 beat/cycle with out_ready held high.
// Backpressure: out_valid && !out_ready freezes the output stage and withholds every in_ready.
// Ports:
//   clk, rst      single clock, synchronous active-high reset
//   bus (slave)   lane inputs in0..in3/in_valid/in_ready, output out_data/out_sel/out_valid/out_ready
//   beat_cnt      beats delivered downstream, wraps modulo 2^CNT_W
module mux4x1_rr_merge #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mux4x1_rr_merge_if.slave     bus,
  output logic [CNT_W-1:0]     beat_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [1:0]        ptr;
  logic [DATA_W-1:0] out_data_q;
  logic [1:0]        out_sel_q;
  logic              out_valid_q;

  logic              load;
  logic [1:0]        grant;
  logic              grant_vld;
  logic [1:0]        idx;
  logic [DATA_W-1:0] grant_dat;

  // Output stage can take a new beat when empty or when it is draining this cycle.
  assign load = !out_valid_q || bus.out_ready;

  // Scan from ptr+3 down to ptr so the last hit (closest to ptr) wins.
  always_comb begin
    grant     = 2'd0;
    grant_vld = 1'b0;
    idx       = ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (bus.in_valid[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    grant_dat = bus.in0;
    case (grant)
      2'd0:    grant_dat = bus.in0;
      2'd1:    grant_dat = bus.in1;
      2'd2:    grant_dat = bus.in2;
      default: grant_dat = bus.in3;
    endcase
  end

  // Reset blocks acceptance combinationally so no lane believes it was taken.
  assign bus.in_ready = (grant_vld && load && !rst) ? (4'b0001 << grant) : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= 2'd0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
      out_valid_q <= 1'b0;
      beat_cnt    <= '0;
    end else begin
      if (load) begin
        if (grant_vld) begin
          out_data_q  <= grant_dat;
          out_sel_q   <= grant;
          out_valid_q <= 1'b1;
          ptr         <= grant + 2'd1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
      if (out_valid_q && bus.out_ready) begin
        beat_cnt <= beat_cnt + CNT_ONE;
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux4x1_rr_merge.sv
// Self-checking bench for mux4x1_rr_merge (DATA_W=4, CNT_W=4 so the counter wrap is reachable).
// Inputs change 1 time unit after the rising edge; everything is checked on the falling edge.
// A negedge monitor predicts in_ready and pushes expected beats into a scoreboard queue.
module tb_mux4x1_rr_merge;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 4;

  logic             clk;
  logic             rst;
  logic [CNT_W-1:0] beat_cnt;

  mux4x1_rr_merge_if #(.DATA_W(DATA_W)) bus ();

  mux4x1_rr_merge #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .beat_cnt (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic             mon_en = 1'b0;
  logic [1:0]       m_ptr  = 2'd0;
  logic             m_vld  = 1'b0;
  logic [CNT_W-1:0] m_cnt  = '0;
  logic [5:0]       sb[$];
  logic [1:0]       m_g;
  logic             m_gv;
  logic             m_ld;
  logic [3:0]       m_rdy;
  logic [1:0]       m_idx;
  logic [5:0]       m_front;

  function automatic logic [3:0] lane_dat(input logic [1:0] k);
    case (k)
      2'd0:    return bus.in0;
      2'd1:    return bus.in1;
      2'd2:    return bus.in2;
      default: return bus.in3;
    endcase
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      m_ld = !m_vld || bus.out_ready;
      m_gv = 1'b0;
      m_g  = 2'd0;
      for (int i = 0; i < 4; i++) begin
        m_idx = m_ptr + 2'(i);
        if (!m_gv && bus.in_valid[m_idx]) begin
          m_gv = 1'b1;
          m_g  = m_idx;
        end
      end
      m_rdy = (m_gv && m_ld && !rst) ? (4'b0001 << m_g) : 4'b0000;

      checks++;
      if (bus.in_ready !== m_rdy) begin
        errors++;
        $display("FAIL mon_in_ready: got %b expected %b at %0t", bus.in_ready, m_rdy, $time);
      end
      checks++;
      if (bus.out_valid !== m_vld) begin
        errors++;
        $display("FAIL mon_out_valid: got %b expected %b at %0t", bus.out_valid, m_vld, $time);
      end
      checks++;
      if (beat_cnt !== m_cnt) begin
        errors++;
        $display("FAIL mon_beat_cnt: got %0d expected %0d at %0t", beat_cnt, m_cnt, $time);
      end
      if (m_vld) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL mon_scoreboard_empty: got beat sel=%0d data=%h expected none", bus.out_sel, bus.out_data);
        end else begin
          m_front = sb[0];
          if ({bus.out_sel, bus.out_data} !== m_front) begin
            errors++;
            $display("FAIL mon_beat: got sel=%0d data=%h expected sel=%0d data=%h at %0t",
                     bus.out_sel, bus.out_data, m_front[5:4], m_front[3:0], $time);
          end
        end
      end

      // Advance model to the state the coming rising edge should produce.
      if (rst) begin
        m_ptr = 2'd0;
        m_vld = 1'b0;
        m_cnt = '0;
        sb.delete();
      end else begin
        if (m_vld && bus.out_ready) begin
          m_cnt = m_cnt + 1'b1;
          if (sb.size() != 0) void'(sb.pop_front());
        end
        if (m_ld) begin
          if (m_gv) begin
            sb.push_back({m_g, lane_dat(m_g)});
            m_vld = 1'b1;
            m_ptr = m_g + 2'd1;
          end else begin
            m_vld = 1'b0;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic set_lanes();
    bus.in0 = 4'hA;
    bus.in1 = 4'hB;
    bus.in2 = 4'hC;
    bus.in3 = 4'hE;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.in_valid = 4'b1111;
    bus.out_ready = 1'b1;
    set_lanes();
    step();
    mon_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 4'b0000) begin
        errors++;
        $display("FAIL reset_in_ready: got %b expected 0000", bus.in_ready);
      end
      checks++;
      if (bus.out_valid !== 1'b0 || beat_cnt !== 4'd0 || bus.out_data !== 4'h0 || bus.out_sel !== 2'd0) begin
        errors++;
        $display("FAIL reset_outputs: got vld=%b cnt=%0d data=%h sel=%0d expected 0/0/0/0",
                 bus.out_valid, beat_cnt, bus.out_data, bus.out_sel);
      end
      step();
    end
    rst = 1'b0;
    bus.in_valid = 4'b0000;
  endtask

  task automatic test_single_lane();
    bus.in_valid  = 4'b0100;
    bus.in2       = 4'hD;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_in_ready: got %b expected 0100", bus.in_ready);
    end
    step();
    bus.in_valid = 4'b0000;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 4'hD || bus.out_sel !== 2'd2) begin
      errors++;
      $display("FAIL single_out: got vld=%b data=%h sel=%0d expected 1/d/2",
               bus.out_valid, bus.out_data, bus.out_sel);
    end
    step();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 4'hD || bus.out_sel !== 2'd2) begin
      errors++;
      $display("FAIL idle_hold: got vld=%b data=%h sel=%0d expected 0/d/2",
               bus.out_valid, bus.out_data, bus.out_sel);
    end
    step();
  endtask

  // Leaves the output stage holding lane 2 with the pointer at lane 3.
  task automatic test_round_robin();
    logic [1:0] exp_sel;
    do_reset();
    set_lanes();
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k > 0) begin
        exp_sel = 2'((k - 1) % 4);
        checks++;
        if (bus.out_sel !== exp_sel || beat_cnt !== 4'(k - 1)) begin
          errors++;
          $display("FAIL rr_seq[%0d]: got sel=%0d cnt=%0d expected sel=%0d cnt=%0d",
                   k, bus.out_sel, beat_cnt, exp_sel, k - 1);
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 4'b0000 || bus.out_valid !== 1'b1 ||
          bus.out_sel !== 2'd2 || bus.out_data !== 4'hC) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got rdy=%b vld=%b sel=%0d data=%h expected 0000/1/2/c",
                 k, bus.in_ready, bus.out_valid, bus.out_sel, bus.out_data);
      end
      step();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 4'b1000) begin
      errors++;
      $display("FAIL bp_release_rdy: got %b expected 1000", bus.in_ready);
    end
    step();
    @(negedge clk);
    checks++;
    if (bus.out_sel !== 2'd3 || bus.out_data !== 4'hE) begin
      errors++;
      $display("FAIL bp_release_out: got sel=%0d data=%h expected 3/e", bus.out_sel, bus.out_data);
    end
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      if (k == 16 || k == 17 || k == 18) begin
        checks++;
        if (beat_cnt !== 4'(k - 1)) begin
          errors++;
          $display("FAIL wrap[%0d]: got %0d expected %0d", k, beat_cnt, (k - 1) % 16);
        end
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.in_valid  = 4'b0010;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b0;
    step();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 4'b0000 || bus.out_valid !== 1'b1 || bus.out_sel !== 2'd1) begin
      errors++;
      $display("FAIL mid_pre_reset: got rdy=%b vld=%b sel=%0d expected 0000/1/1",
               bus.in_ready, bus.out_valid, bus.out_sel);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || beat_cnt !== 4'd0 || bus.in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL mid_post_reset: got vld=%b cnt=%0d rdy=%b expected 0/0/0001",
               bus.out_valid, beat_cnt, bus.in_ready);
    end
    step();
    @(negedge clk);
    checks++;
    if (bus.out_sel !== 2'd0 || bus.out_data !== 4'hA) begin
      errors++;
      $display("FAIL mid_first_beat: got sel=%0d data=%h expected 0/a", bus.out_sel, bus.out_data);
    end
    step();
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 4'b0000;
    bus.out_ready = 1'b0;
    bus.in0 = '0;
    bus.in1 = '0;
    bus.in2 = '0;
    bus.in3 = '0;
    test_reset();
    test_single_lane();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    bus.in_valid = 4'b0000;
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
